// File: rtl/dummy_accelerator_multislot.sv
// Multi-slot dummy accelerator: in-order circular queue of in-flight ALU ops,
// each op retiring after a per-op latency given by its immediate.
module dummy_accelerator_multislot #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_WIDTH = 11,
    parameter int unsigned NSLOTS    = 4,
    parameter type         tag_type_t = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic [WIDTH-1:0]     rs1_value_i,
    input  logic [IMM_WIDTH-1:0] imm_i,
    input  logic [1:0]           op_i,
    input  tag_type_t            tag_i,
    output logic [WIDTH-1:0]     result_o,
    output tag_type_t            tag_o,
    output logic                 busy_o
);

    localparam int unsigned PTR_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    logic                 slot_valid_q  [NSLOTS];
    logic                 slot_valid_d  [NSLOTS];
    logic [WIDTH-1:0]     slot_result_q [NSLOTS];
    logic [WIDTH-1:0]     slot_result_d [NSLOTS];
    tag_type_t            slot_tag_q    [NSLOTS];
    tag_type_t            slot_tag_d    [NSLOTS];
    logic [IMM_WIDTH-1:0] slot_rem_q    [NSLOTS];
    logic [IMM_WIDTH-1:0] slot_rem_d    [NSLOTS];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic               accept;
    logic               retire;
    logic [SH_W-1:0]    rot_amt;
    logic [2*WIDTH-1:0] rot_full;
    logic [WIDTH-1:0]   op_result;

    // Operation datapath, evaluated at acceptance time
    always_comb begin
        rot_amt   = SH_W'(64'(imm_i) % 64'(WIDTH));
        rot_full  = {rs1_value_i, rs1_value_i} << rot_amt;
        op_result = rs1_value_i;
        unique case (op_i)
            OP_XOR: op_result = rs1_value_i ^ WIDTH'(imm_i);
            OP_ADD: op_result = rs1_value_i + WIDTH'(imm_i);
            OP_ROL: op_result = rot_full[2*WIDTH-1 -: WIDTH];
            OP_MOV: op_result = rs1_value_i;
        endcase
    end

    assign ready_o  = (count_q < CNT_W'(NSLOTS));
    assign valid_o  = slot_valid_q[rd_ptr_q] && (slot_rem_q[rd_ptr_q] == '0);
    assign result_o = slot_result_q[rd_ptr_q];
    assign tag_o    = slot_tag_q[rd_ptr_q];
    assign busy_o   = (count_q != '0);

    assign accept = valid_i && ready_o && !flush_i;
    assign retire = valid_o && ready_i && !flush_i;

    // Queue next-state: countdown, retire at head, accept at tail, flush wins
    always_comb begin
        slot_valid_d  = slot_valid_q;
        slot_result_d = slot_result_q;
        slot_tag_d    = slot_tag_q;
        slot_rem_d    = slot_rem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        for (int i = 0; i < NSLOTS; i++) begin
            if (slot_valid_q[i] && (slot_rem_q[i] != '0)) begin
                slot_rem_d[i] = slot_rem_q[i] - IMM_WIDTH'(1);
            end
        end

        if (flush_i) begin
            for (int i = 0; i < NSLOTS; i++) begin
                slot_valid_d[i] = 1'b0;
                slot_rem_d[i]   = '0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (retire) begin
                slot_valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d               = rd_ptr_q + PTR_W'(1);
            end
            // The tail slot is free whenever ready_o is high, so no clash with the head
            if (accept) begin
                slot_valid_d[wr_ptr_q]  = 1'b1;
                slot_result_d[wr_ptr_q] = op_result;
                slot_tag_d[wr_ptr_q]    = tag_i;
                slot_rem_d[wr_ptr_q]    = imm_i;
                wr_ptr_d                = wr_ptr_q + PTR_W'(1);
            end
            unique case ({accept, retire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSLOTS; i++) begin
                slot_valid_q[i]  <= 1'b0;
                slot_result_q[i] <= '0;
                slot_tag_q[i]    <= '0;
                slot_rem_q[i]    <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_valid_q  <= slot_valid_d;
            slot_result_q <= slot_result_d;
            slot_tag_q    <= slot_tag_d;
            slot_rem_q    <= slot_rem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_dummy_accelerator_multislot.sv
// Directed bench for dummy_accelerator_multislot: latency, op results, ordering,
// backpressure, flush and asynchronous reset, plus a randomized in-order stream.
module tb_dummy_accelerator_multislot;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] rs1;
    logic [10:0] imm;
    logic [1:0]  op;
    logic [7:0]  tag_i;
    logic [31:0] result_o;
    logic [7:0]  tag_o;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    dummy_accelerator_multislot #(
        .WIDTH      (32),
        .IMM_WIDTH  (11),
        .NSLOTS     (4),
        .tag_type_t (logic [7:0])
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .rs1_value_i (rs1),
        .imm_i       (imm),
        .op_i        (op),
        .tag_i       (tag_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for the op datapath
    function automatic logic [31:0] model(input logic [31:0] a, input logic [10:0] im,
                                          input logic [1:0] o);
        logic [31:0] r;
        int          sh;
        r = a;
        case (o)
            2'b00: r = a ^ {21'b0, im};
            2'b01: r = a + {21'b0, im};
            2'b10: begin
                sh = int'(im) % 32;
                for (int k = 0; k < sh; k++) r = {r[30:0], r[31]};
            end
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [10:0] im, input logic [1:0] o,
                         input logic [7:0] t);
        valid_i = 1'b1;
        rs1     = a;
        imm     = im;
        op      = o;
        tag_i   = t;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    logic [39:0] exp_q[$];
    logic [39:0] e;
    int          n;
    int          idx, retired, cyc, mcnt;
    logic        do_acc, do_ret;

    initial begin
        rst_ni  = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        rs1     = '0;
        imm     = '0;
        op      = '0;
        tag_i   = '0;

        // Reset values
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_busy", busy_o, 0);
        repeat (2) tick();
        @(negedge clk) rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_valid", valid_o, 0);

        // XOR with 15-cycle latency
        ready_i = 1'b1;
        drive(32'h0000_00FF, 11'h00F, 2'b00, 8'd1);
        tick();
        valid_i = 1'b0;
        chk("xor_busy", busy_o, 1);
        wait_valid(n);
        chk("xor_latency", n, 15);
        chk("xor_result", result_o, 32'h0000_00F0);
        chk("xor_tag", tag_o, 1);
        tick();
        chk("xor_retired_valid", valid_o, 0);
        chk("xor_retired_busy", busy_o, 0);

        // Zero latency add
        drive(32'hFFFF_FFFF, 11'd0, 2'b01, 8'd2);
        tick();
        valid_i = 1'b0;
        chk("add0_valid", valid_o, 1);
        chk("add0_result", result_o, 32'hFFFF_FFFF);
        chk("add0_tag", tag_o, 2);
        tick();
        chk("add0_retired", busy_o, 0);

        // Add wraps modulo 2^32
        drive(32'hFFFF_FFFF, 11'd1, 2'b01, 8'd3);
        tick();
        valid_i = 1'b0;
        chk("add1_not_early", valid_o, 0);
        tick();
        chk("add1_valid", valid_o, 1);
        chk("add1_result", result_o, 32'h0000_0000);
        chk("add1_tag", tag_o, 3);
        tick();

        // Rotate by imm mod WIDTH (33 -> 1)
        drive(32'h8000_0001, 11'd33, 2'b10, 8'd4);
        tick();
        valid_i = 1'b0;
        wait_valid(n);
        chk("rol_latency", n, 33);
        chk("rol_result", result_o, 32'h0000_0003);
        chk("rol_tag", tag_o, 4);
        tick();

        // Pass-through
        drive(32'hDEAD_BEEF, 11'd2, 2'b11, 8'd5);
        tick();
        valid_i = 1'b0;
        wait_valid(n);
        chk("mov_latency", n, 2);
        chk("mov_result", result_o, 32'hDEAD_BEEF);
        tick();
        chk("mov_retired", busy_o, 0);

        // Four back-to-back ops: full queue, in-order retirement
        for (int t = 0; t < 4; t++) begin
            drive(32'h100 + 32'(t), (t == 0) ? 11'd20 : 11'd3, 2'b11, 8'(t));
            tick();
        end
        valid_i = 1'b0;
        chk("full_ready", ready_o, 0);
        chk("full_busy", busy_o, 1);
        n = 3;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("head_latency", n, 20);
        chk("head_tag", tag_o, 0);
        chk("head_result", result_o, 32'h100);
        for (int t = 1; t < 4; t++) begin
            tick();
            chk("order_valid", valid_o, 1);
            chk("order_tag", tag_o, t);
            chk("order_result", result_o, 32'h100 + t);
            chk("order_ready", ready_o, 1);
        end
        tick();
        chk("order_done_valid", valid_o, 0);
        chk("order_done_busy", busy_o, 0);

        // Backpressure hold for 10 cycles
        ready_i = 1'b0;
        drive(32'h1234_5678, 11'd0, 2'b11, 8'd5);
        tick();
        valid_i = 1'b0;
        repeat (10) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_result", result_o, 32'h1234_5678);
            chk("stall_tag", tag_o, 5);
            tick();
        end
        ready_i = 1'b1;
        tick();
        chk("stall_release", valid_o, 0);
        chk("stall_release_busy", busy_o, 0);

        // Randomized stream of 100 ops with random downstream readiness
        idx = 0; retired = 0; cyc = 0; mcnt = 0;
        while (retired < 100 && cyc < 5000) begin
            chk("rnd_ready", ready_o, (mcnt < 4));
            ready_i = 1'($urandom_range(0, 1));
            if (idx < 100) drive($urandom, 11'($urandom_range(0, 12)), 2'($urandom_range(0, 3)), 8'(idx));
            else valid_i = 1'b0;
            do_acc = valid_i && ready_o;
            do_ret = valid_o && ready_i;
            if (do_ret) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", result_o, e[31:0]);
                    chk("rnd_tag", tag_o, e[39:32]);
                    retired++;
                    mcnt--;
                end
            end
            if (do_acc) begin
                exp_q.push_back({tag_i, model(rs1, imm, op)});
                idx++;
                mcnt++;
            end
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        chk("rnd_all_retired", retired, 100);
        chk("rnd_all_issued", idx, 100);
        chk("rnd_idle", busy_o, 0);

        // Flush with three ops in flight and a concurrent valid_i
        ready_i = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            drive(32'(t), 11'd10, 2'b11, 8'(t));
            tick();
        end
        drive(32'h99, 11'd0, 2'b11, 8'd9);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", valid_o, 0);
        chk("flush_busy", busy_o, 0);
        chk("flush_ready", ready_o, 1);
        repeat (15) tick();
        chk("flush_nothing_emerges", valid_o, 0);
        chk("flush_still_idle", busy_o, 0);

        // Asynchronous reset mid-operation
        ready_i = 1'b0;
        drive(32'h0000_ABCD, 11'd0, 2'b11, 8'd8);
        tick();
        drive(32'h0000_1234, 11'd5, 2'b11, 8'd9);
        tick();
        valid_i = 1'b0;
        chk("pre_rst_valid", valid_o, 1);
        chk("pre_rst_result", result_o, 32'h0000_ABCD);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_result", result_o, 0);
        chk("async_rst_tag", tag_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_ready", ready_o, 1);
        @(negedge clk) rst_ni = 1'b1;
        ready_i = 1'b1;
        repeat (10) tick();
        chk("after_rst_valid", valid_o, 0);
        chk("after_rst_busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
